// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit_pkg
//  Description : Shared types and constants for the instruction fetch unit:
//                FSM state encoding, default widths/reset address and the
//                NOP word presented when the IF/ID register is empty.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_fetch_unit_pkg;

  localparam int          C_XLEN     = 32;
  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
  // addi x0, x0, 0
  localparam logic [31:0] C_NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

endpackage : pc_fetch_unit_pkg
`default_nettype wire

// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit_if
//  Description : Instruction-memory request/response bus. The fetch unit is
//                the master; the memory is the slave. At most one request is
//                outstanding and responses return in order.
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_fetch_unit_if
  import pc_fetch_unit_pkg::*;
#(
  parameter int XLEN = C_XLEN
);

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface : pc_fetch_unit_if
`default_nettype wire

// File: rtl/pc_fetch_unit_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid_buf
//  Description : One-entry holding register for a fetch response that lands
//                while decode is stalled. A flush empties it unconditionally.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_skid_buf
  import pc_fetch_unit_pkg::*;
#(
  parameter int XLEN = C_XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic            flush,
  input  logic            drain,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [XLEN-1:0] in_instr,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [XLEN-1:0] out_instr
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic [XLEN-1:0] r_instr;

  // Capture on load, empty on drain; flush wins so a redirect never leaves a stale word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_instr    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (in_valid) begin
      r_valid    <= 1'b1;
      r_pc       <= in_pc;
      r_pc_plus4 <= in_pc_plus4;
      r_instr    <= in_instr;
    end else if (drain) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid    = r_valid;
  assign out_pc       = r_pc;
  assign out_pc_plus4 = r_pc_plus4;
  assign out_instr    = r_instr;

endmodule : fetch_skid_buf
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit
//  Description : Program counter and instruction fetch stage. Issues one
//                word-aligned request at a time, loads the IF/ID register on
//                response, honours decode stalls through a one-entry skid
//                buffer and handles branch/jump redirects, discarding a
//                response that is already in flight.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = C_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(C_RESET_PC)
) (
  input  logic             clk,
  input  logic             reset_n,
  pc_fetch_unit_if.master  imem,
  input  logic             pc_src,
  input  logic [XLEN-1:0]  target,
  input  logic             stall,
  output logic             if_valid,
  output logic [XLEN-1:0]  if_pc,
  output logic [XLEN-1:0]  if_pc_plus4,
  output logic [XLEN-1:0]  if_instr,
  output logic             flush
);

  localparam logic [XLEN-1:0] C_NOP_WORD   = XLEN'(C_NOP);
  localparam logic [XLEN-1:0] C_ALIGN_MASK = ~(XLEN'(3));

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_if_valid;
  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] r_if_pc_plus4;
  logic [XLEN-1:0] r_if_instr;
  logic            r_flush;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_target_aligned;
  logic            w_skid_load;
  logic            w_skid_drain;
  logic            w_skid_valid;
  logic [XLEN-1:0] w_skid_pc;
  logic [XLEN-1:0] w_skid_pc_plus4;
  logic [XLEN-1:0] w_skid_instr;

  // Sequential PC wraps naturally at the top of the address space
  assign w_pc_plus4       = r_pc + XLEN'(4);
  assign w_target_aligned = target & C_ALIGN_MASK;

  // Park a response in the skid buffer when decode cannot take it; release it once stall drops
  assign w_skid_load  = (r_state == WAIT) && imem.rvalid && stall && !pc_src && !w_skid_valid;
  assign w_skid_drain = (r_state == WAIT) && w_skid_valid && !stall && !pc_src;

  fetch_skid_buf #(
    .XLEN (XLEN)
  ) u_skid (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (w_skid_load),
    .flush        (pc_src),
    .drain        (w_skid_drain),
    .in_pc        (r_pc),
    .in_pc_plus4  (w_pc_plus4),
    .in_instr     (imem.rdata),
    .out_valid    (w_skid_valid),
    .out_pc       (w_skid_pc),
    .out_pc_plus4 (w_skid_pc_plus4),
    .out_instr    (w_skid_instr)
  );

  // Fetch FSM, PC and IF/ID register; a redirect overrides everything else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_if_valid    <= 1'b0;
      r_if_pc       <= '0;
      r_if_pc_plus4 <= '0;
      r_if_instr    <= '0;
      r_flush       <= 1'b0;
    end else begin
      r_flush <= pc_src;

      // Decode consumes IF/ID every unstalled cycle; refill below or leave a bubble
      if (!stall) begin
        r_if_valid <= 1'b0;
        r_if_instr <= C_NOP_WORD;
      end

      case (r_state)
        IDLE: begin
          r_if_instr <= C_NOP_WORD;
          r_pc       <= pc_src ? w_target_aligned : RESET_PC;
          r_state    <= REQ;
        end

        REQ: begin
          if (pc_src) begin
            // Ungranted request is simply retargeted; a granted one must be dropped
            r_pc <= w_target_aligned;
            if (imem.gnt) begin
              r_state <= DROP;
            end
          end else if (imem.gnt) begin
            r_state <= WAIT;
          end
        end

        WAIT: begin
          if (pc_src) begin
            r_pc <= w_target_aligned;
            // Nothing left on the bus if the response is here now or already parked
            r_state <= (imem.rvalid || w_skid_valid) ? REQ : DROP;
          end else if (w_skid_valid) begin
            if (!stall) begin
              r_if_valid    <= 1'b1;
              r_if_pc       <= w_skid_pc;
              r_if_pc_plus4 <= w_skid_pc_plus4;
              r_if_instr    <= w_skid_instr;
              r_state       <= REQ;
            end
          end else if (imem.rvalid) begin
            r_pc <= w_pc_plus4;
            if (!stall) begin
              r_if_valid    <= 1'b1;
              r_if_pc       <= r_pc;
              r_if_pc_plus4 <= w_pc_plus4;
              r_if_instr    <= imem.rdata;
              r_state       <= REQ;
            end
          end
        end

        DROP: begin
          if (pc_src) begin
            r_pc <= w_target_aligned;
          end
          // Exactly one response is owed; swallow it and resume at the redirected PC
          if (imem.rvalid) begin
            r_state <= REQ;
          end
        end

        default: r_state <= IDLE;
      endcase

      if (pc_src) begin
        r_if_valid <= 1'b0;
        r_if_instr <= C_NOP_WORD;
      end
    end
  end

  assign imem.req    = (r_state == REQ);
  assign imem.addr   = r_pc;
  assign if_valid    = r_if_valid;
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc_plus4;
  assign if_instr    = r_if_instr;
  assign flush       = r_flush;

endmodule : pc_fetch_unit
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_unit
//  Description : Directed bench for pc_fetch_unit with a one-outstanding
//                memory responder whose response data is ~address.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pc_src;
  logic        stall;
  logic [31:0] target;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch_unit_if #(.XLEN(32)) bus ();

  pc_fetch_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem        (bus),
    .pc_src      (pc_src),
    .target      (target),
    .stall       (stall),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4),
    .if_instr    (if_instr),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  // Memory responder: handshakes seen at posedge, rvalid driven at negedge mem_lat cycles later
  int          mem_lat  = 1;
  int          hs_count = 0;
  int          hs_done  = 0;
  int          lat_cnt  = 0;
  logic [31:0] resp_addr;
  logic [31:0] log_q[$];

  always @(posedge clk) begin
    if (reset_n && bus.req && bus.gnt) begin
      hs_count++;
      resp_addr = bus.addr;
      log_q.push_back(bus.addr);
    end
  end

  always @(negedge clk) begin
    bus.rvalid = 1'b0;
    if (!reset_n) begin
      lat_cnt = 0;
      hs_done = hs_count;
    end else begin
      if (hs_done != hs_count) begin
        hs_done = hs_count;
        lat_cnt = mem_lat;
      end
      if (lat_cnt != 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          bus.rvalid = 1'b1;
          bus.rdata  = ~resp_addr;
        end
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.req !== 1'b0 || bus.addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus: req=%0b addr=%h expected req=0 addr=0", bus.req, bus.addr);
    end
    n_checks++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h0 || if_instr !== 32'h0 || flush !== 1'b0) begin
      n_fail++; $display("FAIL reset_ifid: v=%0b pc=%h pc4=%h instr=%h flush=%0b expected all zero", if_valid, if_pc, if_pc_plus4, if_instr, flush);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h0 || if_instr !== 32'h0000_0013 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL first_req: req=%0b addr=%h instr=%h v=%0b expected 1/00000000/00000013/0", bus.req, bus.addr, if_instr, if_valid);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      int waited = 0;
      logic [31:0] exp_pc;
      exp_pc = 32'(i * 4);
      do begin @(negedge clk); waited++; end while (if_valid !== 1'b1 && waited < 8);
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== exp_pc || if_pc_plus4 !== exp_pc + 32'd4 || if_instr !== ~exp_pc) begin
        n_fail++; $display("FAIL seq_fetch%0d: v=%0b pc=%h pc4=%h instr=%h expected pc=%h instr=%h", i, if_valid, if_pc, if_pc_plus4, if_instr, exp_pc, ~exp_pc);
      end
    end
    n_checks++;
    if (log_q.size() < 3 || log_q[0] !== 32'h0 || log_q[1] !== 32'h4 || log_q[2] !== 32'h8) begin
      n_fail++; $display("FAIL seq_order: %0d beats, expected 0,4,8 in order", log_q.size());
    end
  endtask

  task automatic test_redirect_wait();
    int waited = 0;
    mem_lat = 3;
    while (bus.req !== 1'b1 && waited < 8) begin @(negedge clk); waited++; end
    @(negedge clk);            // request granted, now waiting for a slow response
    pc_src = 1'b1; target = 32'h0000_0100;
    @(negedge clk);
    pc_src = 1'b0;
    n_checks++;
    if (flush !== 1'b1 || if_valid !== 1'b0 || bus.req !== 1'b0) begin
      n_fail++; $display("FAIL redir_drop: flush=%0b v=%0b req=%0b expected 1/0/0", flush, if_valid, bus.req);
    end
    @(negedge clk);
    n_checks++;
    if (flush !== 1'b0 || if_valid !== 1'b0 || bus.req !== 1'b0) begin
      n_fail++; $display("FAIL redir_hold: flush=%0b v=%0b req=%0b expected 0/0/0", flush, if_valid, bus.req);
    end
    @(negedge clk);            // stale response was swallowed at the last edge
    mem_lat = 1;
    n_checks++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h100 || if_valid !== 1'b0 || flush !== 1'b0) begin
      n_fail++; $display("FAIL redir_req: req=%0b addr=%h v=%0b flush=%0b expected 1/00000100/0/0", bus.req, bus.addr, if_valid, flush);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== ~32'h100) begin
      n_fail++; $display("FAIL redir_target: v=%0b pc=%h instr=%h expected 1/00000100/%h", if_valid, if_pc, if_instr, ~32'h100);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h100) begin
        n_fail++; $display("FAIL stall_hold%0d: v=%0b pc=%h expected 1/00000100", i, if_valid, if_pc);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h104 || if_pc_plus4 !== 32'h108 || if_instr !== ~32'h104 || bus.addr !== 32'h108) begin
      n_fail++; $display("FAIL stall_release: v=%0b pc=%h pc4=%h instr=%h addr=%h expected pc=00000104 addr=00000108", if_valid, if_pc, if_pc_plus4, if_instr, bus.addr);
    end
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_nodup: v=%0b expected 0", if_valid);
    end
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h108 || if_instr !== ~32'h108) begin
      n_fail++; $display("FAIL stall_next: v=%0b pc=%h instr=%h expected 1/00000108", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_align_grant_redirect();
    pc_src = 1'b1; target = 32'h0000_0203;   // coincides with a grant of 0x10C
    @(negedge clk);
    pc_src = 1'b0;
    n_checks++;
    if (flush !== 1'b1 || bus.req !== 1'b0 || bus.addr !== 32'h200) begin
      n_fail++; $display("FAIL align_drop: flush=%0b req=%0b addr=%h expected 1/0/00000200", flush, bus.req, bus.addr);
    end
    @(negedge clk);
    n_checks++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h200 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL align_req: req=%0b addr=%h v=%0b expected 1/00000200/0", bus.req, bus.addr, if_valid);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_pc_plus4 !== 32'h204 || if_instr !== ~32'h200) begin
      n_fail++; $display("FAIL align_fetch: v=%0b pc=%h pc4=%h instr=%h expected 00000200/00000204", if_valid, if_pc, if_pc_plus4, if_instr);
    end
  endtask

  task automatic test_retarget();
    bus.gnt = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h204) begin
      n_fail++; $display("FAIL req_stable: req=%0b addr=%h expected 1/00000204", bus.req, bus.addr);
    end
    pc_src = 1'b1; target = 32'h0000_0300;
    @(negedge clk);
    pc_src = 1'b0; bus.gnt = 1'b1;
    n_checks++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h300 || flush !== 1'b1) begin
      n_fail++; $display("FAIL retarget: req=%0b addr=%h flush=%0b expected 1/00000300/1", bus.req, bus.addr, flush);
    end
    @(negedge clk);
    n_checks++;
    if (log_q.size() < 2 || log_q[log_q.size()-1] !== 32'h300 || log_q[log_q.size()-2] !== 32'h200) begin
      n_fail++; $display("FAIL retarget_beats: %0d beats, expected last two 00000200,00000300", log_q.size());
    end
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h300 || if_instr !== ~32'h300) begin
      n_fail++; $display("FAIL retarget_fetch: v=%0b pc=%h instr=%h expected 1/00000300", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_redirect_with_rvalid();
    @(negedge clk);            // granted 0x304; response lands at the next edge
    pc_src = 1'b1; target = 32'h0000_0400;
    @(negedge clk);
    pc_src = 1'b0;
    n_checks++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h400 || flush !== 1'b1 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_rvalid: req=%0b addr=%h flush=%0b v=%0b expected 1/00000400/1/0", bus.req, bus.addr, flush, if_valid);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h400 || if_instr !== ~32'h400) begin
      n_fail++; $display("FAIL redir_rvalid_fetch: v=%0b pc=%h instr=%h expected 1/00000400", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_reset_mid();
    mem_lat = 3;
    @(negedge clk);            // request 0x404 granted, response pending
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.req !== 1'b0 || bus.addr !== 32'h0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h0 || if_instr !== 32'h0 || flush !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: req=%0b addr=%h v=%0b pc=%h pc4=%h instr=%h flush=%0b expected all zero", bus.req, bus.addr, if_valid, if_pc, if_pc_plus4, if_instr, flush);
    end
    repeat (2) @(negedge clk);
    mem_lat = 1;
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h0 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL restart_req: req=%0b addr=%h v=%0b expected 1/00000000/0", bus.req, bus.addr, if_valid);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL restart_fetch: v=%0b pc=%h instr=%h expected 1/00000000/ffffffff", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_wrap();
    pc_src = 1'b1; target = 32'hFFFF_FFFC;
    @(negedge clk);
    pc_src = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.req !== 1'b1 || bus.addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_req: req=%0b addr=%h expected 1/fffffffc", bus.req, bus.addr);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0 || if_instr !== 32'h3 || bus.addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap: v=%0b pc=%h pc4=%h instr=%h addr=%h expected fffffffc/00000000/00000003/00000000", if_valid, if_pc, if_pc_plus4, if_instr, bus.addr);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    pc_src  = 1'b0;
    stall   = 1'b0;
    target  = 32'h0;
    bus.gnt = 1'b1;
    test_reset();
    test_sequential();
    test_redirect_wait();
    test_stall();
    test_align_grant_redirect();
    test_retarget();
    test_redirect_with_rvalid();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pc_fetch_unit
`default_nettype wire
